// File: rtl/c64_keymap_pkg.sv
// PS/2 set-2 to C64 keyboard matrix mapping: named key positions and the
// {ext, scancode} -> {valid, needs_shift, restore, col, row} lookup.
package c64_keymap_pkg;

    typedef struct packed {
        logic       valid;
        logic       needs_shift;
        logic       restore;
        logic [2:0] col;
        logic [2:0] row;
    } km_t;

    localparam logic [2:0] LSHIFT_C     = 3'd1;
    localparam logic [2:0] LSHIFT_R     = 3'd7;
    localparam logic [5:0] LSHIFT_IDX   = {LSHIFT_C, LSHIFT_R};
    localparam logic [8:0] RESTORE_CODE = 9'h17D;

    function automatic km_t km_key(input logic [2:0] col, input logic [2:0] row,
                                   input logic sh);
        km_t m;
        m = {1'b1, sh, 1'b0, col, row};
        return m;
    endfunction

    function automatic km_t c64_keymap(input logic ext, input logic [7:0] code);
        km_t m;
        case ({ext, code})
            9'h066: m = km_key(3'd0, 3'd0, 1'b0);
            9'h05A: m = km_key(3'd0, 3'd1, 1'b0);
            9'h174: m = km_key(3'd0, 3'd2, 1'b0);
            9'h16B: m = km_key(3'd0, 3'd2, 1'b1);
            9'h083: m = km_key(3'd0, 3'd3, 1'b0);
            9'h005: m = km_key(3'd0, 3'd4, 1'b0);
            9'h004: m = km_key(3'd0, 3'd5, 1'b0);
            9'h003: m = km_key(3'd0, 3'd6, 1'b0);
            9'h172: m = km_key(3'd0, 3'd7, 1'b0);
            9'h175: m = km_key(3'd0, 3'd7, 1'b1);
            9'h026: m = km_key(3'd1, 3'd0, 1'b0);
            9'h01D: m = km_key(3'd1, 3'd1, 1'b0);
            9'h01C: m = km_key(3'd1, 3'd2, 1'b0);
            9'h025: m = km_key(3'd1, 3'd3, 1'b0);
            9'h01A: m = km_key(3'd1, 3'd4, 1'b0);
            9'h01B: m = km_key(3'd1, 3'd5, 1'b0);
            9'h024: m = km_key(3'd1, 3'd6, 1'b0);
            9'h012: m = km_key(LSHIFT_C, LSHIFT_R, 1'b0);
            9'h02E: m = km_key(3'd2, 3'd0, 1'b0);
            9'h02D: m = km_key(3'd2, 3'd1, 1'b0);
            9'h023: m = km_key(3'd2, 3'd2, 1'b0);
            9'h036: m = km_key(3'd2, 3'd3, 1'b0);
            9'h021: m = km_key(3'd2, 3'd4, 1'b0);
            9'h02B: m = km_key(3'd2, 3'd5, 1'b0);
            9'h02C: m = km_key(3'd2, 3'd6, 1'b0);
            9'h022: m = km_key(3'd2, 3'd7, 1'b0);
            9'h03D: m = km_key(3'd3, 3'd0, 1'b0);
            9'h035: m = km_key(3'd3, 3'd1, 1'b0);
            9'h034: m = km_key(3'd3, 3'd2, 1'b0);
            9'h03E: m = km_key(3'd3, 3'd3, 1'b0);
            9'h032: m = km_key(3'd3, 3'd4, 1'b0);
            9'h033: m = km_key(3'd3, 3'd5, 1'b0);
            9'h03C: m = km_key(3'd3, 3'd6, 1'b0);
            9'h02A: m = km_key(3'd3, 3'd7, 1'b0);
            9'h046: m = km_key(3'd4, 3'd0, 1'b0);
            9'h043: m = km_key(3'd4, 3'd1, 1'b0);
            9'h03B: m = km_key(3'd4, 3'd2, 1'b0);
            9'h045: m = km_key(3'd4, 3'd3, 1'b0);
            9'h03A: m = km_key(3'd4, 3'd4, 1'b0);
            9'h042: m = km_key(3'd4, 3'd5, 1'b0);
            9'h044: m = km_key(3'd4, 3'd6, 1'b0);
            9'h031: m = km_key(3'd4, 3'd7, 1'b0);
            9'h079: m = km_key(3'd5, 3'd0, 1'b0);
            9'h04D: m = km_key(3'd5, 3'd1, 1'b0);
            9'h04B: m = km_key(3'd5, 3'd2, 1'b0);
            9'h04E: m = km_key(3'd5, 3'd3, 1'b0);
            9'h049: m = km_key(3'd5, 3'd4, 1'b0);
            9'h052: m = km_key(3'd5, 3'd5, 1'b0);
            9'h054: m = km_key(3'd5, 3'd6, 1'b0);
            9'h041: m = km_key(3'd5, 3'd7, 1'b0);
            9'h05D: m = km_key(3'd6, 3'd0, 1'b0);
            9'h05B: m = km_key(3'd6, 3'd1, 1'b0);
            9'h04C: m = km_key(3'd6, 3'd2, 1'b0);
            9'h16C: m = km_key(3'd6, 3'd3, 1'b0);
            9'h059: m = km_key(3'd6, 3'd4, 1'b0);
            9'h055: m = km_key(3'd6, 3'd5, 1'b0);
            9'h04A: m = km_key(3'd6, 3'd7, 1'b0);
            9'h016: m = km_key(3'd7, 3'd0, 1'b0);
            9'h00E: m = km_key(3'd7, 3'd1, 1'b0);
            9'h014: m = km_key(3'd7, 3'd2, 1'b0);
            9'h01E: m = km_key(3'd7, 3'd3, 1'b0);
            9'h029: m = km_key(3'd7, 3'd4, 1'b0);
            9'h011: m = km_key(3'd7, 3'd5, 1'b0);
            9'h015: m = km_key(3'd7, 3'd6, 1'b0);
            9'h076: m = km_key(3'd7, 3'd7, 1'b0);
            RESTORE_CODE: m = {1'b1, 1'b0, 1'b1, 3'd0, 3'd0};
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_c64_keymap.sv
// Combinational wrapper around the package keymap so it can be checked on its own.
module ps2_c64_keymap
    import c64_keymap_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic [8:0] map_o
);

    assign map_o = c64_keymap(ext_i, code_i);

endmodule

// File: rtl/ps2_c64_matrix.sv
// C64 keyboard matrix image fed by PS/2 key events, scanned by CIA1 in
// either direction through a purely combinational readback.
module ps2_c64_matrix
    import c64_keymap_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  pai,
    input  logic [7:0]  pbi,
    output logic [7:0]  pbo,
    output logic [7:0]  pao,
    output logic        restore_n
);

    km_t         km_s;
    logic        strobe_s;
    logic        press_s;
    logic [5:0]  idx_s;
    logic        old_bit_s;
    logic [63:0] eff_s;

    logic [63:0] mat_q, mat_d;
    logic        lshift_q, lshift_d;
    logic [1:0]  vshift_q, vshift_d;
    logic        restore_q, restore_d;

    ps2_c64_keymap u_keymap (
        .ext_i  (ps2_key[8]),
        .code_i (ps2_key[7:0]),
        .map_o  (km_s)
    );

    assign strobe_s = ps2_key[10];
    assign press_s  = ps2_key[9];
    assign idx_s    = {km_s.col, km_s.row};
    assign old_bit_s = mat_q[idx_s];

    // Next-state: shift keys only count on real 0->1 / 1->0 edges so typematic repeats are harmless.
    always_comb begin
        mat_d     = mat_q;
        lshift_d  = lshift_q;
        vshift_d  = vshift_q;
        restore_d = restore_q;
        if (strobe_s && km_s.valid) begin
            if (km_s.restore) begin
                restore_d = press_s;
            end else if (idx_s == LSHIFT_IDX) begin
                lshift_d = press_s;
            end else begin
                mat_d[idx_s] = press_s;
                if (km_s.needs_shift && press_s && !old_bit_s && vshift_q != 2'd3) begin
                    vshift_d = vshift_q + 2'd1;
                end else if (km_s.needs_shift && !press_s && old_bit_s && vshift_q != 2'd0) begin
                    vshift_d = vshift_q - 2'd1;
                end else begin
                    vshift_d = vshift_q;
                end
            end
        end else begin
            mat_d = mat_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_q     <= 64'd0;
            lshift_q  <= 1'b0;
            vshift_q  <= 2'd0;
            restore_q <= 1'b0;
        end else begin
            mat_q     <= mat_d;
            lshift_q  <= lshift_d;
            vshift_q  <= vshift_d;
            restore_q <= restore_d;
        end
    end

    // Readback: left shift position merges physical and virtual shift.
    always_comb begin
        eff_s             = mat_q;
        eff_s[LSHIFT_IDX] = lshift_q | (vshift_q != 2'd0);
        pbo = 8'hFF;
        pao = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                pbo[r] = pbo[r] & ~(eff_s[{c[2:0], r[2:0]}] & ~pai[c]);
                pao[c] = pao[c] & ~(eff_s[{c[2:0], r[2:0]}] & ~pbi[r]);
            end
        end
    end

    assign restore_n = ~restore_q;

endmodule

// File: tb/tb_ps2_c64_matrix.sv
// Self-checking bench: directed vector table, reset corner cases, then
// randomized events checked against a key-state reference model.
module tb_ps2_c64_matrix;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'd0;
    logic [7:0]  pai = 8'hFF;
    logic [7:0]  pbi = 8'hFF;
    logic [7:0]  pbo, pao;
    logic        restore_n;

    int errs = 0;
    int checks = 0;

    ps2_c64_matrix dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .pai       (pai),
        .pbi       (pbi),
        .pbo       (pbo),
        .pao       (pao),
        .restore_n (restore_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       ev;
        bit       press;
        bit [8:0] code;
        bit [7:0] pai;
        bit [7:0] pbi;
        bit [7:0] pbo;
        bit [7:0] pao;
        bit       rn;
    } vec_t;

    // kind: 0 = matrix key, 1 = physical left shift, 2 = restore
    typedef struct {
        bit [8:0] code;
        int       col;
        int       row;
        bit       sh;
        int       kind;
    } mk_t;

    vec_t tbl[$];
    mk_t  keys[$];

    bit [7:0] m_down [8];
    bit       m_lshift;
    int       m_vshift;
    bit       m_restore;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input bit [8:0] code, input bit press);
        @(negedge clk);
        ps2_key = {1'b1, press, code};
        @(negedge clk);
        ps2_key = 11'd0;
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 8; c++) m_down[c] = 8'h00;
        m_lshift = 1'b0;
        m_vshift = 0;
        m_restore = 1'b0;
    endfunction

    function automatic void model_apply(input bit [8:0] code, input bit press);
        bit old;
        for (int i = 0; i < keys.size(); i++) begin
            if (keys[i].code == code) begin
                if (keys[i].kind == 2) m_restore = press;
                else if (keys[i].kind == 1) m_lshift = press;
                else begin
                    old = m_down[keys[i].col][keys[i].row];
                    m_down[keys[i].col][keys[i].row] = press;
                    if (keys[i].sh && press && !old && m_vshift < 3) m_vshift++;
                    if (keys[i].sh && !press && old && m_vshift > 0) m_vshift--;
                end
                return;
            end
        end
    endfunction

    function automatic bit model_key(input int c, input int r);
        if (c == 1 && r == 7) return m_lshift || (m_vshift > 0);
        return m_down[c][r];
    endfunction

    function automatic bit [7:0] model_pbo(input bit [7:0] a);
        bit [7:0] o = 8'hFF;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if (!a[c] && model_key(c, r)) o[r] = 1'b0;
        return o;
    endfunction

    function automatic bit [7:0] model_pao(input bit [7:0] b);
        bit [7:0] o = 8'hFF;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if (!b[r] && model_key(c, r)) o[c] = 1'b0;
        return o;
    endfunction

    task automatic rand_readback();
        for (int k = 0; k < 2; k++) begin
            pai = 8'($urandom);
            pbi = 8'($urandom);
            if ($urandom_range(0, 2) == 0) pai = ~(8'h01 << $urandom_range(0, 7));
            #1;
            check("rand_pbo", pbo, model_pbo(pai));
            check("rand_pao", pao, model_pao(pbi));
            check("rand_restore_n", {7'd0, restore_n}, {7'd0, ~m_restore});
        end
    endtask

    function automatic void addv(input bit ev, input bit press, input bit [8:0] code,
                                 input bit [7:0] a, input bit [7:0] b,
                                 input bit [7:0] eo_b, input bit [7:0] eo_a, input bit rn);
        vec_t v;
        v = '{ev, press, code, a, b, eo_b, eo_a, rn};
        tbl.push_back(v);
    endfunction

    function automatic void addk(input bit [8:0] code, input int c, input int r,
                                 input bit sh, input int kind);
        mk_t m;
        m = '{code, c, r, sh, kind};
        keys.push_back(m);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [8:0] unmapped [3];
        bit [8:0] code_a, code_b;
        bit       pr_a, pr_b;

        unmapped[0] = 9'h000; unmapped[1] = 9'h0FF; unmapped[2] = 9'h1FF;
        addk(9'h05A, 0, 1, 1'b0, 0); addk(9'h059, 6, 4, 1'b0, 0);
        addk(9'h01C, 1, 2, 1'b0, 0); addk(9'h029, 7, 4, 1'b0, 0);
        addk(9'h014, 7, 2, 1'b0, 0); addk(9'h011, 7, 5, 1'b0, 0);
        addk(9'h076, 7, 7, 1'b0, 0); addk(9'h005, 0, 4, 1'b0, 0);
        addk(9'h172, 0, 7, 1'b0, 0); addk(9'h174, 0, 2, 1'b0, 0);
        addk(9'h175, 0, 7, 1'b1, 0); addk(9'h16B, 0, 2, 1'b1, 0);
        addk(9'h17D, 0, 0, 1'b0, 2); addk(9'h012, 1, 7, 1'b0, 1);

        //    ev press code    pai    pbi    pbo    pao    rn
        addv(0, 0, 9'h000, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 1, 9'h05A, 8'hFE, 8'hFF, 8'hFD, 8'hFF, 1);
        addv(1, 0, 9'h05A, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 1, 9'h175, 8'hFD, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(0, 0, 9'h000, 8'hFE, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(1, 0, 9'h175, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(0, 0, 9'h000, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 1, 9'h012, 8'hFD, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(1, 1, 9'h175, 8'hFD, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(1, 1, 9'h175, 8'hFE, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(1, 0, 9'h175, 8'hFD, 8'hFF, 8'h7F, 8'hFF, 1);
        addv(0, 0, 9'h000, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 0, 9'h012, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 0, 9'h175, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 1);
        addv(1, 1, 9'h029, 8'hFF, 8'hEF, 8'hFF, 8'h7F, 1);
        addv(1, 1, 9'h01C, 8'hFF, 8'hEF, 8'hFF, 8'h7F, 1);
        addv(0, 0, 9'h000, 8'hFF, 8'hFB, 8'hFF, 8'hFD, 1);
        addv(0, 0, 9'h000, 8'hFF, 8'hEB, 8'hFF, 8'h7D, 1);
        addv(0, 0, 9'h000, 8'h7F, 8'hFF, 8'hEF, 8'hFF, 1);
        addv(1, 0, 9'h029, 8'hFF, 8'hEB, 8'hFF, 8'hFD, 1);
        addv(1, 0, 9'h01C, 8'hFF, 8'hEB, 8'hFF, 8'hFF, 1);
        addv(1, 1, 9'h17D, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 0);
        addv(1, 1, 9'h000, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        addv(1, 0, 9'h17D, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1);

        repeat (3) @(negedge clk);
        #1;
        check("reset_pbo", pbo, 8'hFF);
        check("reset_restore_n", {7'd0, restore_n}, 8'h01);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].ev) send(tbl[i].code, tbl[i].press);
            else @(negedge clk);
            pai = tbl[i].pai;
            pbi = tbl[i].pbi;
            #1;
            check($sformatf("vec%0d_pbo", i), pbo, tbl[i].pbo);
            check($sformatf("vec%0d_pao", i), pao, tbl[i].pao);
            check($sformatf("vec%0d_restore_n", i), {7'd0, restore_n}, {7'd0, tbl[i].rn});
        end

        // Asynchronous reset in mid-hold clears everything without a clock edge.
        send(9'h05A, 1'b1);
        send(9'h17D, 1'b1);
        pai = 8'hFE;
        #1;
        check("hold_pbo", pbo, 8'hFD);
        check("hold_restore_n", {7'd0, restore_n}, 8'h00);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pbo", pbo, 8'hFF);
        check("async_rst_restore_n", {7'd0, restore_n}, 8'h01);
        @(negedge clk);
        ps2_key = {1'b1, 1'b1, 9'h05A};
        @(negedge clk);
        ps2_key = 11'd0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("strobe_in_reset_lost", pbo, 8'hFF);

        // Release of a never-pressed shift key must not underflow the shift count.
        send(9'h16B, 1'b0);
        send(9'h175, 1'b1);
        send(9'h175, 1'b0);
        pai = 8'hFD;
        #1;
        check("no_underflow_pbo", pbo, 8'hFF);

        model_reset();
        for (int it = 0; it < 400; it++) begin
            if (it % 8 == 7) begin
                code_a = keys[$urandom_range(0, keys.size() - 1)].code;
                code_b = keys[$urandom_range(0, keys.size() - 1)].code;
                pr_a = 1'($urandom);
                pr_b = 1'($urandom);
                @(negedge clk);
                ps2_key = {1'b1, pr_a, code_a};
                @(negedge clk);
                ps2_key = {1'b1, pr_b, code_b};
                @(negedge clk);
                ps2_key = 11'd0;
                model_apply(code_a, pr_a);
                model_apply(code_b, pr_b);
            end else begin
                if ($urandom_range(0, 9) == 0) code_a = unmapped[$urandom_range(0, 2)];
                else code_a = keys[$urandom_range(0, keys.size() - 1)].code;
                pr_a = 1'($urandom);
                send(code_a, pr_a);
                model_apply(code_a, pr_a);
            end
            rand_readback();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
